// File: rtl/defines.sv
// Shared types for the hazard/forwarding unit: forward-select encoding,
// the shadow pipeline slot record and the slot match helper.
package defines;

    // Width of the rd field carried in a shadow slot. Register indices
    // narrower than this are zero-extended on entry to a slot.
    localparam int SLOT_RD_WIDTH = 8;

    typedef logic [SLOT_RD_WIDTH-1:0] slot_rd_t;

    // Operand source selection for the instruction in EX.
    typedef enum logic [1:0] {
        FW_NONE = 2'b00,
        FW_MEM  = 2'b01,
        FW_WB   = 2'b10
    } fw_sel_e;

    // One shadow pipeline slot: what the instruction in that stage writes.
    typedef struct packed {
        logic     valid;
        slot_rd_t rd;
        logic     reg_write;
        logic     mem_read;
    } pipe_slot_t;

    localparam pipe_slot_t EMPTY_SLOT = '0;

    // A source depends on a slot only when the source is actually read,
    // is not x0, and the slot holds a live instruction writing that register.
    function automatic logic slot_match(input pipe_slot_t slot,
                                        input slot_rd_t   src,
                                        input logic       used);
        return used && (src != '0) && slot.valid && slot.reg_write
               && (slot.rd == src);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-source forwarding priority comparator: the younger producer (EX slot)
// beats the older one (MEM slot).
module fwd_select
    import defines::*;
#(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] src_addr,
    input  logic                      src_used,
    input  pipe_slot_t                ex_slot,
    input  pipe_slot_t                mem_slot,
    output fw_sel_e                   fw_sel,
    output logic                      ex_hit
);

    slot_rd_t src_ext;
    logic     mem_hit;

    assign src_ext = slot_rd_t'(src_addr);

    // Match against both producers and pick the youngest one.
    always_comb begin
        ex_hit  = slot_match(ex_slot, src_ext, src_used);
        mem_hit = slot_match(mem_slot, src_ext, src_used);
        fw_sel  = FW_NONE;
        if (ex_hit) begin
            fw_sel = FW_MEM;
        end else if (mem_hit) begin
            fw_sel = FW_WB;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and forwarding control for a 5-stage pipeline. Tracks
// shadow EX/MEM/WB slots, registers the forward selects for the instruction
// entering EX, and produces stall/flush/bubble controls.
module hazard_forward_unit
    import defines::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int PERF_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] ID_rs1_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] ID_rs2_addr_i,
    input  logic                      ID_use_rs1_i,
    input  logic                      ID_use_rs2_i,
    input  logic [REG_ADDR_WIDTH-1:0] ID_rd_addr_i,
    input  logic                      ID_RegWrite_i,
    input  logic                      ID_MemRead_i,
    input  logic                      EX_branch_taken_i,
    input  logic                      MEM_stall_i,
    output logic                      PC_write_o,
    output logic                      IF_ID_write_o,
    output logic                      IF_ID_flush_o,
    output logic                      ID_EX_bubble_o,
    output fw_sel_e                   EX_forwardA_o,
    output fw_sel_e                   EX_forwardB_o,
    output logic [PERF_WIDTH-1:0]     stall_count_o
);

    pipe_slot_t            ex_slot;
    pipe_slot_t            mem_slot;
    pipe_slot_t            wb_slot;
    pipe_slot_t            id_slot;
    fw_sel_e               sel_a;
    fw_sel_e               sel_b;
    fw_sel_e               fw_a_q;
    fw_sel_e               fw_b_q;
    logic                  ex_hit_a;
    logic                  ex_hit_b;
    logic                  load_use;
    logic                  load_use_stall;
    logic                  insert_bubble;
    logic [PERF_WIDTH-1:0] stall_count_q;

    fwd_select #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
        .src_addr (ID_rs1_addr_i),
        .src_used (ID_use_rs1_i),
        .ex_slot  (ex_slot),
        .mem_slot (mem_slot),
        .fw_sel   (sel_a),
        .ex_hit   (ex_hit_a)
    );

    fwd_select #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
        .src_addr (ID_rs2_addr_i),
        .src_used (ID_use_rs2_i),
        .ex_slot  (ex_slot),
        .mem_slot (mem_slot),
        .fw_sel   (sel_b),
        .ex_hit   (ex_hit_b)
    );

    // Describe the ID instruction as the slot it will occupy once in EX.
    always_comb begin
        id_slot           = EMPTY_SLOT;
        id_slot.valid     = 1'b1;
        id_slot.rd        = slot_rd_t'(ID_rd_addr_i);
        id_slot.reg_write = ID_RegWrite_i;
        id_slot.mem_read  = ID_MemRead_i;
    end

    // Hazard classification and pipeline controls; a memory stall outranks
    // a taken branch, which outranks a load-use stall.
    always_comb begin
        load_use       = ex_slot.mem_read && (ex_hit_a || ex_hit_b);
        load_use_stall = 1'b0;
        insert_bubble  = 1'b0;
        PC_write_o     = 1'b1;
        IF_ID_write_o  = 1'b1;
        IF_ID_flush_o  = 1'b0;
        ID_EX_bubble_o = 1'b0;
        if (!rst_n) begin
            load_use = 1'b0;
        end else if (MEM_stall_i) begin
            PC_write_o    = 1'b0;
            IF_ID_write_o = 1'b0;
        end else if (EX_branch_taken_i) begin
            IF_ID_flush_o  = 1'b1;
            ID_EX_bubble_o = 1'b1;
            insert_bubble  = 1'b1;
        end else if (load_use) begin
            PC_write_o     = 1'b0;
            IF_ID_write_o  = 1'b0;
            ID_EX_bubble_o = 1'b1;
            insert_bubble  = 1'b1;
            load_use_stall = 1'b1;
        end
    end

    // Shadow slots advance each cycle, freeze on a memory stall, and take
    // a bubble in EX on a flush or load-use stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_slot  <= EMPTY_SLOT;
            mem_slot <= EMPTY_SLOT;
            wb_slot  <= EMPTY_SLOT;
        end else if (MEM_stall_i) begin
            ex_slot  <= ex_slot;
            mem_slot <= mem_slot;
            wb_slot  <= wb_slot;
        end else begin
            ex_slot  <= insert_bubble ? EMPTY_SLOT : id_slot;
            mem_slot <= ex_slot;
            wb_slot  <= mem_slot;
        end
    end

    // Forward selects follow the ID instruction into EX; bubbles get none.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fw_a_q <= FW_NONE;
            fw_b_q <= FW_NONE;
        end else if (!MEM_stall_i) begin
            fw_a_q <= insert_bubble ? FW_NONE : sel_a;
            fw_b_q <= insert_bubble ? FW_NONE : sel_b;
        end
    end

    // Count cycles lost to load-use stalls; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= '0;
        end else if (load_use_stall) begin
            stall_count_q <= stall_count_q + PERF_WIDTH'(1);
        end
    end

    assign EX_forwardA_o = fw_a_q;
    assign EX_forwardB_o = fw_b_q;
    assign stall_count_o = stall_count_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed scoreboard bench for hazard_forward_unit.
module tb_hazard_forward_unit;
    import defines::*;

    localparam int RW = 5;
    localparam int PW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [RW-1:0] ID_rs1_addr_i;
    logic [RW-1:0] ID_rs2_addr_i;
    logic          ID_use_rs1_i;
    logic          ID_use_rs2_i;
    logic [RW-1:0] ID_rd_addr_i;
    logic          ID_RegWrite_i;
    logic          ID_MemRead_i;
    logic          EX_branch_taken_i;
    logic          MEM_stall_i;
    logic          PC_write_o;
    logic          IF_ID_write_o;
    logic          IF_ID_flush_o;
    logic          ID_EX_bubble_o;
    fw_sel_e       EX_forwardA_o;
    fw_sel_e       EX_forwardB_o;
    logic [PW-1:0] stall_count_o;

    typedef struct {
        string         tag;
        logic          pc_write;
        logic          if_id_write;
        logic          flush;
        logic          bubble;
        fw_sel_e       fw_a;
        fw_sel_e       fw_b;
        logic [PW-1:0] count;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    hazard_forward_unit #(.REG_ADDR_WIDTH(RW), .PERF_WIDTH(PW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ID_rs1_addr_i     (ID_rs1_addr_i),
        .ID_rs2_addr_i     (ID_rs2_addr_i),
        .ID_use_rs1_i      (ID_use_rs1_i),
        .ID_use_rs2_i      (ID_use_rs2_i),
        .ID_rd_addr_i      (ID_rd_addr_i),
        .ID_RegWrite_i     (ID_RegWrite_i),
        .ID_MemRead_i      (ID_MemRead_i),
        .EX_branch_taken_i (EX_branch_taken_i),
        .MEM_stall_i       (MEM_stall_i),
        .PC_write_o        (PC_write_o),
        .IF_ID_write_o     (IF_ID_write_o),
        .IF_ID_flush_o     (IF_ID_flush_o),
        .ID_EX_bubble_o    (ID_EX_bubble_o),
        .EX_forwardA_o     (EX_forwardA_o),
        .EX_forwardB_o     (EX_forwardB_o),
        .stall_count_o     (stall_count_o)
    );

    task automatic compare_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic compare_fw(input string tag, input fw_sel_e obs, input fw_sel_e exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic compare_cnt(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ID-stage instruction drivers
    task automatic id_alu(input int rd, input int rs1, input int rs2);
        ID_rs1_addr_i = rs1[RW-1:0];
        ID_rs2_addr_i = rs2[RW-1:0];
        ID_use_rs1_i  = 1'b1;
        ID_use_rs2_i  = 1'b1;
        ID_rd_addr_i  = rd[RW-1:0];
        ID_RegWrite_i = 1'b1;
        ID_MemRead_i  = 1'b0;
    endtask

    task automatic id_load(input int rd, input int rs1);
        ID_rs1_addr_i = rs1[RW-1:0];
        ID_rs2_addr_i = '0;
        ID_use_rs1_i  = 1'b1;
        ID_use_rs2_i  = 1'b0;
        ID_rd_addr_i  = rd[RW-1:0];
        ID_RegWrite_i = 1'b1;
        ID_MemRead_i  = 1'b1;
    endtask

    task automatic id_nop();
        ID_rs1_addr_i = '0;
        ID_rs2_addr_i = '0;
        ID_use_rs1_i  = 1'b0;
        ID_use_rs2_i  = 1'b0;
        ID_rd_addr_i  = '0;
        ID_RegWrite_i = 1'b0;
        ID_MemRead_i  = 1'b0;
    endtask

    // Record the expectation for the cycle whose inputs were just driven.
    task automatic apply_stimulus(input string tag, input logic pcw, input logic ifw,
                                  input logic fl, input logic bub, input fw_sel_e fa,
                                  input fw_sel_e fb, input int cnt);
        exp_t e;
        e.tag = tag; e.pc_write = pcw; e.if_id_write = ifw; e.flush = fl;
        e.bubble = bub; e.fw_a = fa; e.fw_b = fb; e.count = cnt[PW-1:0];
        sb_q.push_back(e);
    endtask

    // Sample on the falling edge and compare against the oldest expectation.
    task automatic check_output();
        exp_t e;
        @(negedge clk);
        checks++;
        assert (sb_q.size() > 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard_empty: observed=0 expected=1");
            return;
        end
        e = sb_q.pop_front();
        compare_bit({e.tag, ".pc_write"}, PC_write_o, e.pc_write);
        compare_bit({e.tag, ".if_id_write"}, IF_ID_write_o, e.if_id_write);
        compare_bit({e.tag, ".flush"}, IF_ID_flush_o, e.flush);
        compare_bit({e.tag, ".bubble"}, ID_EX_bubble_o, e.bubble);
        compare_fw({e.tag, ".fwA"}, EX_forwardA_o, e.fw_a);
        compare_fw({e.tag, ".fwB"}, EX_forwardB_o, e.fw_b);
        compare_cnt({e.tag, ".count"}, stall_count_o, e.count);
    endtask

    task automatic step(input string tag, input logic pcw, input logic ifw, input logic fl,
                        input logic bub, input fw_sel_e fa, input fw_sel_e fb, input int cnt);
        apply_stimulus(tag, pcw, ifw, fl, bub, fa, fb, cnt);
        check_output();
        @(posedge clk);
        #1;
    endtask

    task automatic step_normal(input string tag, input fw_sel_e fa, input fw_sel_e fb, input int cnt);
        step(tag, 1'b1, 1'b1, 1'b0, 1'b0, fa, fb, cnt);
    endtask

    task automatic drain(input int cnt);
        id_nop();
        step_normal("drain0", FW_NONE, FW_NONE, cnt);
        step_normal("drain1", FW_NONE, FW_NONE, cnt);
    endtask

    initial begin
        // Reset with branch and memory stall asserted: outputs must ignore them
        rst_n = 1'b0;
        EX_branch_taken_i = 1'b1;
        MEM_stall_i = 1'b1;
        id_nop();
        step_normal("reset", FW_NONE, FW_NONE, 0);
        rst_n = 1'b1;
        EX_branch_taken_i = 1'b0;
        MEM_stall_i = 1'b0;

        // Back-to-back ALU dependency
        id_alu(5, 1, 2);  step_normal("s1_add", FW_NONE, FW_NONE, 0);
        id_alu(6, 5, 1);  step_normal("s1_sub_id", FW_NONE, FW_NONE, 0);
        id_nop();         step_normal("s1_sub_ex", FW_MEM, FW_NONE, 0);
        drain(0);

        // One intervening instruction
        id_alu(5, 1, 2);  step_normal("s2_add", FW_NONE, FW_NONE, 0);
        id_nop();         step_normal("s2_gap", FW_NONE, FW_NONE, 0);
        id_alu(7, 5, 5);  step_normal("s2_or_id", FW_NONE, FW_NONE, 0);
        id_nop();         step_normal("s2_or_ex", FW_WB, FW_WB, 0);
        drain(0);

        // Both prior instructions write x5: youngest wins
        id_alu(5, 1, 2);  step_normal("s3_add1", FW_NONE, FW_NONE, 0);
        id_alu(5, 3, 4);  step_normal("s3_add2", FW_NONE, FW_NONE, 0);
        id_alu(6, 5, 1);  step_normal("s3_sub_id", FW_NONE, FW_NONE, 0);
        id_nop();         step_normal("s3_sub_ex", FW_MEM, FW_NONE, 0);
        drain(0);

        // x0 is never forwarded
        id_alu(0, 1, 2);  step_normal("s4_wr_x0", FW_NONE, FW_NONE, 0);
        id_alu(8, 0, 0);  step_normal("s4_rd_x0_id", FW_NONE, FW_NONE, 0);
        id_nop();         step_normal("s4_rd_x0_ex", FW_NONE, FW_NONE, 0);
        drain(0);

        // Load-use: one stall cycle, then forward from WB
        id_load(5, 1);    step_normal("s5_lw", FW_NONE, FW_NONE, 0);
        id_alu(6, 5, 2);  step("s5_stall", 1'b0, 1'b0, 1'b0, 1'b1, FW_NONE, FW_NONE, 0);
                          step_normal("s5_after_stall", FW_NONE, FW_NONE, 1);
        id_nop();         step_normal("s5_add_ex", FW_WB, FW_NONE, 1);
        drain(1);

        // Load-use coincident with taken branch: flush wins, no count
        id_load(5, 1);    step_normal("s6_lw", FW_NONE, FW_NONE, 1);
        id_alu(6, 5, 2);
        EX_branch_taken_i = 1'b1;
        step("s6_flush", 1'b1, 1'b1, 1'b1, 1'b1, FW_NONE, FW_NONE, 1);
        EX_branch_taken_i = 1'b0;
        id_nop();         step_normal("s6_after", FW_NONE, FW_NONE, 1);
                          step_normal("s6_next", FW_NONE, FW_NONE, 1);
        drain(1);

        // Memory stall for 3 cycles while a forward is live
        id_alu(5, 1, 2);  step_normal("s7_add", FW_NONE, FW_NONE, 1);
        id_alu(6, 5, 1);  step_normal("s7_sub", FW_NONE, FW_NONE, 1);
        id_alu(7, 6, 5);
        MEM_stall_i = 1'b1;
        step("s7_freeze1", 1'b0, 1'b0, 1'b0, 1'b0, FW_MEM, FW_NONE, 1);
        EX_branch_taken_i = 1'b1;
        step("s7_freeze2", 1'b0, 1'b0, 1'b0, 1'b0, FW_MEM, FW_NONE, 1);
        EX_branch_taken_i = 1'b0;
        step("s7_freeze3", 1'b0, 1'b0, 1'b0, 1'b0, FW_MEM, FW_NONE, 1);
        MEM_stall_i = 1'b0;
        step_normal("s7_release", FW_MEM, FW_NONE, 1);
        id_nop();         step_normal("s7_or_ex", FW_MEM, FW_WB, 1);
        drain(1);

        // Reset pulsed during a load-use stall
        id_load(5, 1);    step_normal("s8_lw", FW_NONE, FW_NONE, 1);
        id_alu(6, 5, 2);
        apply_stimulus("s8_stall", 1'b0, 1'b0, 1'b0, 1'b1, FW_NONE, FW_NONE, 1);
        check_output();
        #1 rst_n = 1'b0;
        apply_stimulus("s8_in_reset", 1'b1, 1'b1, 1'b0, 1'b0, FW_NONE, FW_NONE, 0);
        check_output();
        #1 rst_n = 1'b1;
        apply_stimulus("s8_release", 1'b1, 1'b1, 1'b0, 1'b0, FW_NONE, FW_NONE, 0);
        check_output();
        @(posedge clk);
        #1;
        id_nop();         step_normal("s8_add_ex", FW_NONE, FW_NONE, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 Parameter: REG_ADDR_WIDTH, default 5, register-index width.
REQ-002 Parameter: PERF_WIDTH, default 32, stall-counter width.
REQ-003 Clock and reset are fixed: one clock; reset is asynchronous and active-low.
REQ-004 Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ID_rs1_addr_i  in  REG_ADDR_WIDTH  rs1 index of the ID-stage instruction.
- ID_rs2_addr_i  in  REG_ADDR_WIDTH  rs2 index of the ID-stage instruction.
- ID_use_rs1_i  in  1  ID instruction reads rs1.
- ID_use_rs2_i  in  1  ID instruction reads rs2.
- ID_rd_addr_i  in  REG_ADDR_WIDTH  destination of the ID instruction.
- ID_RegWrite_i  in  1  ID instruction writes rd.
- ID_MemRead_i  in  1  ID instruction is a load.
- EX_branch_taken_i  in  1  redirect resolved in EX this cycle.
- MEM_stall_i  in  1  data memory not ready; freezes the whole pipeline.
- PC_write_o  out  1  PC may update.
- IF_ID_write_o  out  1  IF/ID register may load.
- IF_ID_flush_o  out  1  IF/ID register loads a bubble.
- ID_EX_bubble_o  out  1  ID/EX register loads a bubble.
- EX_forwardA_o  out  fw_sel_e  operand-A source for the EX instruction; registered.
- EX_forwardB_o  out  fw_sel_e  operand-B source for the EX instruction; registered.
- stall_count_o  out  PERF_WIDTH  count of load-use stall cycles.

Function
REQ-005 The block shall keep shadow EX, MEM and WB slots, each holding {valid, rd, RegWrite, MemRead}, that advance once per cycle unless frozen.
REQ-006 A hazard source match shall require all of: source used, source index nonzero, slot valid, slot RegWrite, and slot rd equal to the source index.
REQ-007 The next forward selection for each source shall be FW_MEM on a match with the EX slot, else FW_WB on a match with the MEM slot, else FW_NONE; the EX slot shall win when both match.
REQ-008 That selection shall be registered into EX_forwardA_o/EX_forwardB_o at the edge the ID instruction enters EX, giving one cycle of latency.
REQ-009 Load-use hazard: EX slot MemRead set and a REQ-006 match on either source.
REQ-010 On a load-use hazard, the block shall drive PC_write_o=0, IF_ID_write_o=0 and ID_EX_bubble_o=1, hold the stall for exactly one cycle, and increment stall_count_o by 1.
REQ-011 During a load-use stall, the EX slot shall take a bubble with forward selects FW_NONE.
REQ-012 After a load-use stall, the re-evaluated selection shall be FW_WB.
REQ-013 On EX_branch_taken_i=1, the block shall drive IF_ID_flush_o=1 and ID_EX_bubble_o=1 with PC_write_o=1, and the EX slot shall take a bubble with FW_NONE selects.
REQ-014 Priority shall be MEM_stall_i, then EX_branch_taken_i, then load-use; a flush in the same cycle as a load-use hazard shall cancel the stall and leave the counter unchanged.
REQ-015 With MEM_stall_i=1, the block shall drive PC_write_o=0 and IF_ID_write_o=0, with flush and bubble outputs at 0, and all shadow slots, forward registers and the counter shall hold.
REQ-016 stall_count_o shall wrap modulo 2^PERF_WIDTH.
REQ-017 The stall, flush and bubble outputs shall be combinational from the inputs and current state.

Reset
REQ-018 While rst_n=0, the block shall clear all slot valid bits, set both forward outputs to FW_NONE, clear stall_count_o to 0, and drive PC_write_o=1, IF_ID_write_o=1, IF_ID_flush_o=0 and ID_EX_bubble_o=0.
REQ-019 Reset asserted mid-stall shall abort the stall; the first cycle after release shall show no hazard.

Structure
REQ-020 fw_sel_e (FW_NONE=2'b00, FW_MEM=2'b01, FW_WB=2'b10) and the pipe-slot struct shall live in package defines.
REQ-021 The block shall contain one sub-module, fwd_select, instantiated twice; it is the combinational per-source priority comparator.

Verification
REQ-022 The bench shall cover these directed scenarios:
- Back-to-back ALU ops (add x5; sub x6,x5,x1): -> EX_forwardA_o=FW_MEM in the sub's EX cycle, no stall.
- One intervening instruction (add x5; nop; or x7,x5,x5): -> forwardA=forwardB=FW_WB.
- Both prior instructions write x5: -> FW_MEM.
- Write to x0 followed by a read of x0: -> FW_NONE.
- lw x5 followed by add x6,x5,x2: -> one cycle with PC_write_o=0 and ID_EX_bubble_o=1; stall_count_o goes 0->1; the add then gets FW_WB.
- Load-use coincident with EX_branch_taken_i=1: -> IF_ID_flush_o=1, no stall, counter unchanged.
- MEM_stall_i held 3 cycles during a forward: -> outputs and counter frozen, and the forward is still correct after release.
- rst_n pulsed low during a load-use stall: -> all outputs at reset values, counter 0.
